// File: rtl/fpu_issue_ctl.sv
// rtl/fpu_issue_ctl.sv - FPU issue/scheduling controller with scoreboard and writeback arbitration
//
// Routes one decoded FP op per cycle to the FMA pipe, the single-cycle short
// unit or the iterative div/sqrt unit. It tracks pending FP destinations in a
// scoreboard and owns the single FPU writeback port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dec_fpu_*           decode-side op handshake, packet, sources, destination
//   fpu_ex_pkt          registered packet of the last accepted op
//   fpu_pipe_issue      1-cycle start pulse to the FMA unit
//   fpu_short_issue     1-cycle start pulse to the short unit
//   fpu_div_start       1-cycle start pulse to the div/sqrt unit
//   fpu_div_done/ack    div result handshake (done held until ack)
//   fpu_wb_*            writeback valid/reg/file/result-source
//   fpu_sb_busy         scoreboard, one bit per FP register
//   fpu_ctl_err         pulse when a load/store packet reaches the FPU
//
// Packet layout: [2:0] rm, [25:3] one-hot-ish op flags (see F_* below).
module fpu_issue_ctl #(
  parameter int FMA_LAT = 4,
  parameter int NFREG   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_fpu_valid,
  output logic             dec_fpu_ready,
  input  logic [25:0]      dec_fpu_pkt,
  input  logic [4:0]       dec_fpu_rs1,
  input  logic [4:0]       dec_fpu_rs2,
  input  logic [4:0]       dec_fpu_rs3,
  input  logic [2:0]       dec_fpu_rs_used,
  input  logic [4:0]       dec_fpu_rd,
  input  logic             dec_fpu_rd_fp,
  output logic [25:0]      fpu_ex_pkt,
  output logic             fpu_pipe_issue,
  output logic             fpu_short_issue,
  output logic             fpu_div_start,
  input  logic             fpu_div_done,
  output logic             fpu_div_ack,
  output logic             fpu_wb_valid,
  output logic [4:0]       fpu_wb_rd,
  output logic             fpu_wb_fp,
  output logic [1:0]       fpu_wb_src,
  output logic [NFREG-1:0] fpu_sb_busy,
  output logic             fpu_ctl_err
);

  // Flag bit positions inside the packet. Bits 12..23 are short-unit ops
  // (sgnj family, min/max, conversions, moves, compare, class).
  localparam int F_MADD  = 3;
  localparam int F_MUL   = 9;   // madd..mul occupy 3..9 contiguously
  localparam int F_DIV   = 10;
  localparam int F_SQRT  = 11;
  localparam int F_LOAD  = 24;
  localparam int F_STORE = 25;

  localparam logic [1:0] SRC_FMA = 2'd0, SRC_SHORT = 2'd1, SRC_DIV = 2'd2;

  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;
  div_state_t div_state_q, div_state_d;

  logic [25:0]      ex_pkt_q, ex_pkt_d;
  logic             pipe_issue_q, pipe_issue_d;
  logic             short_issue_q, short_issue_d;
  logic             div_start_q, div_start_d;
  logic             ctl_err_q, ctl_err_d;
  logic [NFREG-1:0] busy_q, busy_d;
  logic [4:0]       div_rd_q, div_rd_d;
  logic             div_fp_q, div_fp_d;

  // Slot/tag pipe: entry 0 writes back this cycle.
  logic [FMA_LAT-1:0] slot_v_q, slot_v_d;
  logic [FMA_LAT-1:0] slot_fp_q, slot_fp_d;
  logic [4:0]         slot_rd_q  [FMA_LAT];
  logic [4:0]         slot_rd_d  [FMA_LAT];
  logic [1:0]         slot_src_q [FMA_LAT];
  logic [1:0]         slot_src_d [FMA_LAT];

  logic is_ls, is_iter, is_pipe, is_short;
  logic raw, waw, slot_conf, iter_conf, div_block, accept;

  always_comb begin
    is_ls    = dec_fpu_pkt[F_LOAD] | dec_fpu_pkt[F_STORE];
    is_iter  = ~is_ls & (dec_fpu_pkt[F_DIV] | dec_fpu_pkt[F_SQRT]);
    is_pipe  = ~is_ls & ~is_iter & (|dec_fpu_pkt[F_MUL:F_MADD]);
    is_short = ~is_ls & ~is_iter & ~is_pipe;

    raw = (dec_fpu_rs_used[0] & busy_q[dec_fpu_rs1]) |
          (dec_fpu_rs_used[1] & busy_q[dec_fpu_rs2]) |
          (dec_fpu_rs_used[2] & busy_q[dec_fpu_rs3]);
    waw = dec_fpu_rd_fp & busy_q[dec_fpu_rd];
    // A short op lands in entry 0 next cycle, which is where entry 1 shifts to.
    // A pipe op lands in the top entry, which nothing can shift into, so it
    // never collides.
    slot_conf = is_short & slot_v_q[1];
    iter_conf = is_iter & (div_state_q != DIV_IDLE);
    // A pending div result that cannot be acked freezes issue so the FMA
    // pipe drains and the div result is not starved.
    div_block = fpu_div_done & ~fpu_div_ack;

    dec_fpu_ready = ~div_block &
                    ~(dec_fpu_valid & (raw | waw | slot_conf | iter_conf));
    accept = dec_fpu_valid & dec_fpu_ready;
  end

  // Div FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_state_q <= DIV_IDLE;
    else     div_state_q <= div_state_d;
  end

  // Div FSM: next state
  always_comb begin
    div_state_d = div_state_q;
    case (div_state_q)
      DIV_IDLE: if (accept & is_iter) div_state_d = DIV_BUSY;
      DIV_BUSY: if (fpu_div_ack)      div_state_d = DIV_IDLE;
      default:                        div_state_d = DIV_IDLE;
    endcase
  end

  // Div FSM: outputs. The FMA/short slot owns the port when occupied.
  always_comb begin
    fpu_div_ack = fpu_div_done & (div_state_q == DIV_BUSY) & ~slot_v_q[0];
  end

  // Writeback mux
  always_comb begin
    fpu_wb_valid = 1'b0;
    fpu_wb_rd    = 5'd0;
    fpu_wb_fp    = 1'b0;
    fpu_wb_src   = SRC_FMA;
    if (slot_v_q[0]) begin
      fpu_wb_valid = 1'b1;
      fpu_wb_rd    = slot_rd_q[0];
      fpu_wb_fp    = slot_fp_q[0];
      fpu_wb_src   = slot_src_q[0];
    end else if (fpu_div_ack) begin
      fpu_wb_valid = 1'b1;
      fpu_wb_rd    = div_rd_q;
      fpu_wb_fp    = div_fp_q;
      fpu_wb_src   = SRC_DIV;
    end
  end

  // Next-state for datapath registers, scoreboard and slot pipe
  always_comb begin
    ex_pkt_d      = accept ? dec_fpu_pkt : ex_pkt_q;
    pipe_issue_d  = accept & is_pipe;
    short_issue_d = accept & is_short;
    div_start_d   = accept & is_iter;
    ctl_err_d     = accept & is_ls;

    div_rd_d = div_rd_q;
    div_fp_d = div_fp_q;
    if (accept & is_iter) begin
      div_rd_d = dec_fpu_rd;
      div_fp_d = dec_fpu_rd_fp;
    end

    busy_d = busy_q;
    if (fpu_wb_valid & fpu_wb_fp) busy_d[fpu_wb_rd] = 1'b0;
    if (accept & ~is_ls & dec_fpu_rd_fp) busy_d[dec_fpu_rd] = 1'b1;

    for (int i = 0; i < FMA_LAT - 1; i++) begin
      slot_v_d[i]   = slot_v_q[i+1];
      slot_fp_d[i]  = slot_fp_q[i+1];
      slot_rd_d[i]  = slot_rd_q[i+1];
      slot_src_d[i] = slot_src_q[i+1];
    end
    slot_v_d[FMA_LAT-1]   = 1'b0;
    slot_fp_d[FMA_LAT-1]  = 1'b0;
    slot_rd_d[FMA_LAT-1]  = 5'd0;
    slot_src_d[FMA_LAT-1] = SRC_FMA;

    if (accept & is_pipe) begin
      slot_v_d[FMA_LAT-1]   = 1'b1;
      slot_fp_d[FMA_LAT-1]  = dec_fpu_rd_fp;
      slot_rd_d[FMA_LAT-1]  = dec_fpu_rd;
      slot_src_d[FMA_LAT-1] = SRC_FMA;
    end else if (accept & is_short) begin
      slot_v_d[0]   = 1'b1;
      slot_fp_d[0]  = dec_fpu_rd_fp;
      slot_rd_d[0]  = dec_fpu_rd;
      slot_src_d[0] = SRC_SHORT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pkt_q      <= '0;
      pipe_issue_q  <= 1'b0;
      short_issue_q <= 1'b0;
      div_start_q   <= 1'b0;
      ctl_err_q     <= 1'b0;
      busy_q        <= '0;
      div_rd_q      <= 5'd0;
      div_fp_q      <= 1'b0;
      slot_v_q      <= '0;
      slot_fp_q     <= '0;
      for (int i = 0; i < FMA_LAT; i++) begin
        slot_rd_q[i]  <= 5'd0;
        slot_src_q[i] <= 2'd0;
      end
    end else begin
      ex_pkt_q      <= ex_pkt_d;
      pipe_issue_q  <= pipe_issue_d;
      short_issue_q <= short_issue_d;
      div_start_q   <= div_start_d;
      ctl_err_q     <= ctl_err_d;
      busy_q        <= busy_d;
      div_rd_q      <= div_rd_d;
      div_fp_q      <= div_fp_d;
      slot_v_q      <= slot_v_d;
      slot_fp_q     <= slot_fp_d;
      for (int i = 0; i < FMA_LAT; i++) begin
        slot_rd_q[i]  <= slot_rd_d[i];
        slot_src_q[i] <= slot_src_d[i];
      end
    end
  end

  assign fpu_ex_pkt      = ex_pkt_q;
  assign fpu_pipe_issue  = pipe_issue_q;
  assign fpu_short_issue = short_issue_q;
  assign fpu_div_start   = div_start_q;
  assign fpu_ctl_err     = ctl_err_q;
  assign fpu_sb_busy     = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// tb/tb_fpu_issue_ctl.sv - directed self-checking bench for fpu_issue_ctl
module tb_fpu_issue_ctl;

  localparam int P_ADD = 7, P_MUL = 9, P_DIV = 10, P_SQRT = 11;
  localparam int P_SGNJ = 12, P_MIN = 15, P_LOAD = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_fpu_valid = 1'b0;
  logic        dec_fpu_ready;
  logic [25:0] dec_fpu_pkt = '0;
  logic [4:0]  dec_fpu_rs1 = '0, dec_fpu_rs2 = '0, dec_fpu_rs3 = '0;
  logic [2:0]  dec_fpu_rs_used = '0;
  logic [4:0]  dec_fpu_rd = '0;
  logic        dec_fpu_rd_fp = 1'b0;
  logic [25:0] fpu_ex_pkt;
  logic        fpu_pipe_issue, fpu_short_issue, fpu_div_start;
  logic        fpu_div_done = 1'b0;
  logic        fpu_div_ack;
  logic        fpu_wb_valid;
  logic [4:0]  fpu_wb_rd;
  logic        fpu_wb_fp;
  logic [1:0]  fpu_wb_src;
  logic [31:0] fpu_sb_busy;
  logic        fpu_ctl_err;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctl dut (
    .clk(clk), .rst(rst),
    .dec_fpu_valid(dec_fpu_valid), .dec_fpu_ready(dec_fpu_ready),
    .dec_fpu_pkt(dec_fpu_pkt),
    .dec_fpu_rs1(dec_fpu_rs1), .dec_fpu_rs2(dec_fpu_rs2), .dec_fpu_rs3(dec_fpu_rs3),
    .dec_fpu_rs_used(dec_fpu_rs_used), .dec_fpu_rd(dec_fpu_rd), .dec_fpu_rd_fp(dec_fpu_rd_fp),
    .fpu_ex_pkt(fpu_ex_pkt), .fpu_pipe_issue(fpu_pipe_issue),
    .fpu_short_issue(fpu_short_issue), .fpu_div_start(fpu_div_start),
    .fpu_div_done(fpu_div_done), .fpu_div_ack(fpu_div_ack),
    .fpu_wb_valid(fpu_wb_valid), .fpu_wb_rd(fpu_wb_rd), .fpu_wb_fp(fpu_wb_fp),
    .fpu_wb_src(fpu_wb_src), .fpu_sb_busy(fpu_sb_busy), .fpu_ctl_err(fpu_ctl_err)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk(input int flag);
    logic [25:0] p;
    p = '0;
    p[flag] = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int flag, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] used, input logic rd_fp);
    dec_fpu_valid   = 1'b1;
    dec_fpu_pkt     = mk(flag);
    dec_fpu_rd      = rd;
    dec_fpu_rs1     = rs1;
    dec_fpu_rs2     = rs2;
    dec_fpu_rs3     = 5'd0;
    dec_fpu_rs_used = used;
    dec_fpu_rd_fp   = rd_fp;
  endtask

  task automatic idle();
    dec_fpu_valid   = 1'b0;
    dec_fpu_pkt     = '0;
    dec_fpu_rs_used = '0;
  endtask

  // Leaves the bench 1 time unit after a posedge with reset released: cycle 0.
  task automatic do_reset();
    idle();
    fpu_div_done = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    checks++; if (fpu_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b exp 0", fpu_wb_valid); end
    checks++; if (fpu_sb_busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", fpu_sb_busy); end
    checks++; if ({fpu_pipe_issue, fpu_short_issue, fpu_div_start, fpu_div_ack, fpu_ctl_err} !== 5'b0)
      begin errors++; $display("FAIL reset_pulses got %b exp 00000",
        {fpu_pipe_issue, fpu_short_issue, fpu_div_start, fpu_div_ack, fpu_ctl_err}); end
    checks++; if (fpu_ex_pkt !== 26'h0) begin errors++; $display("FAIL reset_ex_pkt got %h exp 0", fpu_ex_pkt); end
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", dec_fpu_ready); end
  endtask

  task automatic test_pipe();
    do_reset();
    present(P_ADD, 5'd3, 5'd1, 5'd2, 3'b011, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL pipe_ready_c0 got %0b exp 1", dec_fpu_ready); end
    tick(); idle(); #1;
    checks++; if (fpu_pipe_issue !== 1'b1 || fpu_short_issue !== 1'b0)
      begin errors++; $display("FAIL pipe_issue_c1 got %0b%0b exp 10", fpu_pipe_issue, fpu_short_issue); end
    checks++; if (fpu_ex_pkt !== mk(P_ADD)) begin errors++; $display("FAIL pipe_ex_pkt got %h exp %h", fpu_ex_pkt, mk(P_ADD)); end
    checks++; if (fpu_sb_busy !== 32'h8) begin errors++; $display("FAIL pipe_busy_c1 got %h exp 8", fpu_sb_busy); end
    tick(); #1;
    checks++; if (fpu_pipe_issue !== 1'b0 || fpu_wb_valid !== 1'b0)
      begin errors++; $display("FAIL pipe_c2 got issue %0b wb %0b exp 0 0", fpu_pipe_issue, fpu_wb_valid); end
    tick(); #1;
    checks++; if (fpu_wb_valid !== 1'b0) begin errors++; $display("FAIL pipe_wb_c3 got %0b exp 0", fpu_wb_valid); end
    tick(); #1;
    checks++; if ({fpu_wb_valid, fpu_wb_rd, fpu_wb_fp, fpu_wb_src} !== {1'b1, 5'd3, 1'b1, 2'd0})
      begin errors++; $display("FAIL pipe_wb_c4 got v%0b rd%0d fp%0b src%0d exp v1 rd3 fp1 src0",
        fpu_wb_valid, fpu_wb_rd, fpu_wb_fp, fpu_wb_src); end
    checks++; if (fpu_sb_busy[3] !== 1'b1) begin errors++; $display("FAIL pipe_busy_c4 got %0b exp 1", fpu_sb_busy[3]); end
    tick(); #1;
    checks++; if (fpu_sb_busy !== 32'h0 || fpu_wb_valid !== 1'b0)
      begin errors++; $display("FAIL pipe_c5 got busy %h wb %0b exp 0 0", fpu_sb_busy, fpu_wb_valid); end
  endtask

  task automatic test_raw();
    do_reset();
    present(P_ADD, 5'd3, 5'd1, 5'd2, 3'b011, 1'b1);
    tick();
    present(P_SGNJ, 5'd4, 5'd3, 5'd3, 3'b011, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (dec_fpu_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c%0d got %0b exp 0", c, dec_fpu_ready); end
      tick();
    end
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL raw_accept_c5 got %0b exp 1", dec_fpu_ready); end
    tick(); idle(); #1;
    checks++; if (fpu_short_issue !== 1'b1) begin errors++; $display("FAIL raw_short_issue_c6 got %0b exp 1", fpu_short_issue); end
    checks++; if ({fpu_wb_valid, fpu_wb_rd, fpu_wb_src} !== {1'b1, 5'd4, 2'd1})
      begin errors++; $display("FAIL raw_wb_c6 got v%0b rd%0d src%0d exp v1 rd4 src1", fpu_wb_valid, fpu_wb_rd, fpu_wb_src); end
    tick(); #1;
    checks++; if (fpu_sb_busy !== 32'h0) begin errors++; $display("FAIL raw_busy_c7 got %h exp 0", fpu_sb_busy); end
  endtask

  task automatic test_slot_conflict();
    do_reset();
    present(P_MUL, 5'd5, 5'd1, 5'd2, 3'b011, 1'b1);
    tick(); idle();
    tick(); tick();
    present(P_MIN, 5'd6, 5'd10, 5'd11, 3'b011, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b0) begin errors++; $display("FAIL slot_stall_c3 got %0b exp 0", dec_fpu_ready); end
    tick(); #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL slot_accept_c4 got %0b exp 1", dec_fpu_ready); end
    checks++; if ({fpu_wb_valid, fpu_wb_rd, fpu_wb_src} !== {1'b1, 5'd5, 2'd0})
      begin errors++; $display("FAIL slot_wb_c4 got v%0b rd%0d src%0d exp v1 rd5 src0", fpu_wb_valid, fpu_wb_rd, fpu_wb_src); end
    tick(); idle(); #1;
    checks++; if ({fpu_wb_valid, fpu_wb_rd, fpu_wb_src, fpu_short_issue} !== {1'b1, 5'd6, 2'd1, 1'b1})
      begin errors++; $display("FAIL slot_wb_c5 got v%0b rd%0d src%0d si%0b exp v1 rd6 src1 si1",
        fpu_wb_valid, fpu_wb_rd, fpu_wb_src, fpu_short_issue); end
  endtask

  task automatic test_div();
    int stall_bad;
    stall_bad = 0;
    do_reset();
    present(P_DIV, 5'd7, 5'd1, 5'd2, 3'b011, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL div_accept_c0 got %0b exp 1", dec_fpu_ready); end
    tick(); idle(); #1;
    checks++; if (fpu_div_start !== 1'b1) begin errors++; $display("FAIL div_start_c1 got %0b exp 1", fpu_div_start); end
    tick();
    present(P_SQRT, 5'd8, 5'd9, 5'd0, 3'b001, 1'b1);
    for (int c = 2; c <= 19; c++) begin
      #1;
      if (dec_fpu_ready !== 1'b0 || fpu_div_ack !== 1'b0 || fpu_wb_valid !== 1'b0) stall_bad++;
      tick();
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL div_hold_c2_19 got %0d bad cycles exp 0", stall_bad); end
    fpu_div_done = 1'b1;
    #1;
    checks++; if ({fpu_div_ack, fpu_wb_valid, fpu_wb_rd, fpu_wb_src, fpu_wb_fp} !== {1'b1, 1'b1, 5'd7, 2'd2, 1'b1})
      begin errors++; $display("FAIL div_ack_c20 got ack%0b v%0b rd%0d src%0d fp%0b exp ack1 v1 rd7 src2 fp1",
        fpu_div_ack, fpu_wb_valid, fpu_wb_rd, fpu_wb_src, fpu_wb_fp); end
    checks++; if (dec_fpu_ready !== 1'b0) begin errors++; $display("FAIL div_sqrt_c20 got %0b exp 0", dec_fpu_ready); end
    tick(); fpu_div_done = 1'b0; #1;
    checks++; if (dec_fpu_ready !== 1'b1 || fpu_sb_busy[7] !== 1'b0)
      begin errors++; $display("FAIL div_sqrt_c21 got rdy%0b busy7 %0b exp 1 0", dec_fpu_ready, fpu_sb_busy[7]); end
    tick(); idle(); #1;
    checks++; if (fpu_div_start !== 1'b1) begin errors++; $display("FAIL div_start_c22 got %0b exp 1", fpu_div_start); end
  endtask

  task automatic test_div_collision();
    do_reset();
    present(P_DIV, 5'd9, 5'd1, 5'd2, 3'b011, 1'b1);
    tick();
    present(P_ADD, 5'd3, 5'd1, 5'd2, 3'b011, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL coll_fadd_c0 got %0b exp 1", dec_fpu_ready); end
    tick(); idle();
    tick(); tick(); tick();
    fpu_div_done = 1'b1;
    present(P_MIN, 5'd12, 5'd10, 5'd11, 3'b011, 1'b1);
    #1;
    checks++; if ({fpu_div_ack, dec_fpu_ready} !== 2'b00)
      begin errors++; $display("FAIL coll_c4 got ack%0b rdy%0b exp 0 0", fpu_div_ack, dec_fpu_ready); end
    checks++; if ({fpu_wb_valid, fpu_wb_rd, fpu_wb_src} !== {1'b1, 5'd3, 2'd0})
      begin errors++; $display("FAIL coll_wb_c4 got v%0b rd%0d src%0d exp v1 rd3 src0", fpu_wb_valid, fpu_wb_rd, fpu_wb_src); end
    tick(); #1;
    checks++; if ({fpu_div_ack, fpu_wb_valid, fpu_wb_rd, fpu_wb_src, dec_fpu_ready} !== {1'b1, 1'b1, 5'd9, 2'd2, 1'b1})
      begin errors++; $display("FAIL coll_c5 got ack%0b v%0b rd%0d src%0d rdy%0b exp ack1 v1 rd9 src2 rdy1",
        fpu_div_ack, fpu_wb_valid, fpu_wb_rd, fpu_wb_src, dec_fpu_ready); end
    tick(); fpu_div_done = 1'b0; idle(); #1;
    checks++; if ({fpu_short_issue, fpu_wb_valid, fpu_wb_rd, fpu_wb_src} !== {1'b1, 1'b1, 5'd12, 2'd1})
      begin errors++; $display("FAIL coll_c6 got si%0b v%0b rd%0d src%0d exp si1 v1 rd12 src1",
        fpu_short_issue, fpu_wb_valid, fpu_wb_rd, fpu_wb_src); end
  endtask

  task automatic test_async_reset();
    do_reset();
    present(P_DIV, 5'd7, 5'd1, 5'd2, 3'b011, 1'b1);
    tick();
    present(P_ADD, 5'd3, 5'd1, 5'd2, 3'b011, 1'b1);
    tick(); idle();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if ({fpu_pipe_issue, fpu_div_start, fpu_wb_valid, fpu_div_ack, fpu_ctl_err} !== 5'b0 || fpu_ex_pkt !== 26'h0)
      begin errors++; $display("FAIL arst_outputs got pi%0b ds%0b wb%0b ack%0b err%0b pkt %h exp all 0",
        fpu_pipe_issue, fpu_div_start, fpu_wb_valid, fpu_div_ack, fpu_ctl_err, fpu_ex_pkt); end
    checks++; if (fpu_sb_busy !== 32'h0) begin errors++; $display("FAIL arst_busy got %h exp 0", fpu_sb_busy); end
    #1 rst = 1'b0;
    tick(); tick(); #1;
    checks++; if (fpu_wb_valid !== 1'b0) begin errors++; $display("FAIL arst_no_wb_c4 got %0b exp 0", fpu_wb_valid); end
    present(P_SQRT, 5'd8, 5'd7, 5'd0, 3'b001, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL arst_fsm_idle got %0b exp 1", dec_fpu_ready); end
    tick(); idle();
  endtask

  task automatic test_load();
    do_reset();
    present(P_LOAD, 5'd5, 5'd2, 5'd0, 3'b000, 1'b1);
    #1;
    checks++; if (dec_fpu_ready !== 1'b1) begin errors++; $display("FAIL ld_ready got %0b exp 1", dec_fpu_ready); end
    tick(); idle(); #1;
    checks++; if (fpu_ctl_err !== 1'b1) begin errors++; $display("FAIL ld_ctl_err got %0b exp 1", fpu_ctl_err); end
    checks++; if ({fpu_pipe_issue, fpu_short_issue, fpu_div_start} !== 3'b0 || fpu_sb_busy !== 32'h0)
      begin errors++; $display("FAIL ld_no_issue got %b busy %h exp 000 0",
        {fpu_pipe_issue, fpu_short_issue, fpu_div_start}, fpu_sb_busy); end
    tick(); #1;
    checks++; if (fpu_ctl_err !== 1'b0 || fpu_wb_valid !== 1'b0)
      begin errors++; $display("FAIL ld_c2 got err%0b wb%0b exp 0 0", fpu_ctl_err, fpu_wb_valid); end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_raw();
    test_slot_conflict();
    test_div();
    test_div_collision();
    test_async_reset();
    test_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctl.md
Name: fpu_issue_ctl

Overview:
- Issue/scheduling controller between decode and the FPU datapaths.
- Accepts one fpu_pkt_t op per cycle and routes it to one of three datapaths:
  - pipelined FMA unit (add/sub/mul/madd family, fixed latency)
  - single-cycle short unit (sgnj/min/max/cvt/mv/compare/class)
  - iterative div/sqrt unit (variable latency)
- Owns the 32-entry FP register scoreboard and arbitrates the single FPU writeback port.

Parameters:
- FMA_LAT, 4, FMA unit latency in cycles, accept to writeback (2..8).
- NFREG, 32, FP registers tracked by the scoreboard.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dec_fpu_valid  in  1  op presented
- dec_fpu_ready  out  1  op accepted when valid&ready
- dec_fpu_pkt  in  26  fpu_pkt_t (23 flags + rm[2:0])
- dec_fpu_rs1, dec_fpu_rs2, dec_fpu_rs3  in  5 each  source FP regs
- dec_fpu_rs_used  in  3  {rs3,rs2,rs1} read by op
- dec_fpu_rd  in  5  destination reg
- dec_fpu_rd_fp  in  1  destination is FP file (0 = integer file)
- fpu_ex_pkt  out  26  registered accepted packet
- fpu_pipe_issue  out  1  1-cycle pulse to FMA unit
- fpu_short_issue  out  1  1-cycle pulse to short unit
- fpu_div_start  out  1  1-cycle pulse to div/sqrt unit
- fpu_div_done  in  1  div result ready; held until ack
- fpu_div_ack  out  1  div result consumed
- fpu_wb_valid  out  1  writeback this cycle
- fpu_wb_rd  out  5  writeback reg
- fpu_wb_fp  out  1  writeback target file
- fpu_wb_src  out  2  result mux: 0 FMA, 1 short, 2 div
- fpu_sb_busy  out  NFREG  scoreboard vector
- fpu_ctl_err  out  1  pulse: load/store pkt received

Behaviour:
- Reset (async, immediate): all outputs 0 except dec_fpu_ready; scoreboard cleared; slot/tag pipe cleared; div FSM → IDLE.

Op classification:
- PIPE: madd|msub|nmsub|nmadd|add|sub|mul.
- ITER: div|sqrt.
- SHORT: all other compute ops.
- load/store: accepted, not dispatched, fpu_ctl_err pulsed next cycle, no scoreboard change.

Stall rule: dec_fpu_ready=0 if any of the following hold; ready is combinational and may depend on pkt fields only while valid.
- RAW: a used rs has fpu_sb_busy set.
- WAW: rd_fp and busy[rd].
- Slot conflict: PIPE with slot[FMA_LAT] reserved, or SHORT with slot[1] reserved.
- ITER while div FSM != IDLE.
- fpu_div_done=1 and not acked this cycle (anti-starvation; blocks all issue).

Accept in cycle t:
- fpu_ex_pkt is loaded and the class pulse is issued in t+1.
- busy[rd] is set visible from t+1 when rd_fp.
- Writeback slots: PIPE reserves slot FMA_LAT (wb at t+FMA_LAT); SHORT reserves slot 1 (wb at t+1); ITER reserves none.

Slot/tag pipe:
- FMA_LAT entries of {valid, rd, rd_fp, src}, shifted down one per cycle.
- Entry 0 drives fpu_wb_* in the current cycle.

Div FSM:
- IDLE → BUSY on ITER accept; rd/rd_fp latched.
- BUSY → IDLE on fpu_div_done & fpu_div_ack.
- fpu_div_ack = fpu_div_done & BUSY & ~slot[0].valid.
- On ack: wb_valid=1, src=2, latched rd in the same cycle.
- A new ITER is acceptable from the cycle after ack.

Scoreboard:
- Clear busy[wb_rd] at end of the wb cycle when wb_fp.
- No same-cycle bypass: a dependent op sees busy in the wb cycle and issues in the cycle after.
- Set and clear of the same register in one cycle cannot occur (WAW stall).

Other rules:
- Exactly one writeback per cycle, guaranteed by construction.
- Two slot reservations in the same slot are impossible.
- At most one accept per cycle.
- Reset mid-operation drops all in-flight tags. The div unit must be reset by the same rst.

Test Plan:
1. Reset, then valid fadd f3←f1,f2 at cycle 0 → ready=1, accepted cycle 0; fpu_pipe_issue cycle 1; wb_valid rd=3 src=0 fp=1 at cycle 4; busy[3]=1 cycles 1..4, 0 at cycle 5.
2. RAW: fadd f3 at cycle 0, fsgnj f4←f3 presented cycle 1 → ready=0 cycles 1..4; accepted cycle 5; short_issue and wb rd=4 src=1 at cycle 6.
3. Slot conflict: fmul f5 at cycle 0, fmin f6 at cycle 3 → stalled cycle 3; accepted cycle 4; wb rd=5 at 4, rd=6 at 5.
4. Div serialization: fdiv f7 accepted cycle 0 → div_start cycle 1; fsqrt f8 presented cycle 2 held off; div_done raised cycle 20 → ack + wb rd=7 src=2 at cycle 20; fsqrt accepted cycle 21.
5. Div/pipe collision: fadd f3 at cycle 0, div_done raised cycle 4 → ack=0 and no issue at cycle 4 (wb rd=3); ack + wb src=2 at cycle 5.
6. Async rst pulse mid-cycle at cycle 2 of test 1 → all outputs and fpu_sb_busy 0 immediately; no wb at cycle 4; FSM IDLE.
7. fld pkt with valid → accepted; fpu_ctl_err=1 next cycle; no issue pulses; scoreboard unchanged.
